// File: rtl/lcd_nibble_tx_if.sv
// Upstream handshake between the LCD init/text sequencer and the nibble write engine.
interface lcd_nibble_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_nibble_only;
  logic       done;

  modport master (
    output in_valid, in_rs, in_data, in_nibble_only,
    input  in_ready, done
  );

  modport slave (
    input  in_valid, in_rs, in_data, in_nibble_only,
    output in_ready, done
  );
endinterface

// File: rtl/lcd_nibble_tx.sv
// HD44780 4-bit write engine: sends one {rs, byte} as two E-strobed nibbles with
// microsecond-scaled setup/pulse/hold, then waits out the controller execution time.
module lcd_nibble_tx #(
  parameter int CYCLES_PER_US = 50,
  parameter int EXEC_US       = 40,
  parameter int LONG_EXEC_US  = 1640
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_nibble_tx_if.slave        up,
  output logic [3:0]            lcd_data,
  output logic                  lcd_e,
  output logic                  lcd_rs,
  output logic                  lcd_rw
);

  localparam int S  = CYCLES_PER_US;
  localparam int P  = CYCLES_PER_US;
  localparam int H  = CYCLES_PER_US;
  localparam int X  = EXEC_US * CYCLES_PER_US;
  localparam int XL = LONG_EXEC_US * CYCLES_PER_US;
  localparam int CW = $clog2(XL + 1);

  // Counters are loaded with length-1 and the phase ends on the cycle they read zero.
  localparam logic [CW-1:0] S_LOAD  = CW'(S - 1);
  localparam logic [CW-1:0] P_LOAD  = CW'(P - 1);
  localparam logic [CW-1:0] H_LOAD  = CW'(H - 1);
  localparam logic [CW-1:0] X_LOAD  = CW'(X - 1);
  localparam logic [CW-1:0] XL_LOAD = CW'(XL - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          nib_only_q, nib_only_d;
  logic          long_q, long_d;
  logic          low_q, low_d;
  logic [3:0]    lcd_data_q, lcd_data_d;
  logic          lcd_e_q, lcd_e_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          done_q, done_d;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      nib_only_q <= 1'b0;
      long_q     <= 1'b0;
      low_q      <= 1'b0;
      lcd_data_q <= '0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      nib_only_q <= nib_only_d;
      long_q     <= long_d;
      low_q      <= low_d;
      lcd_data_q <= lcd_data_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    nib_only_d = nib_only_q;
    long_d     = long_q;
    low_d      = low_q;
    lcd_data_d = lcd_data_q;
    lcd_e_d    = lcd_e_q;
    lcd_rs_d   = lcd_rs_q;

    unique case (state_q)
      ST_IDLE: begin
        if (up.in_valid) begin
          data_d     = up.in_data;
          nib_only_d = up.in_nibble_only;
          // Clear/home commands (0x01..0x03) need the long execution wait.
          long_d     = !up.in_rs && !up.in_nibble_only &&
                       (up.in_data[7:2] == 6'd0) && (up.in_data[1:0] != 2'd0);
          low_d      = 1'b0;
          lcd_rs_d   = up.in_rs;
          lcd_data_d = up.in_data[7:4];
          cnt_d      = S_LOAD;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          lcd_e_d = 1'b1;
          cnt_d   = P_LOAD;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          lcd_e_d = 1'b0;
          cnt_d   = H_LOAD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!low_q && !nib_only_q) begin
          low_d      = 1'b1;
          lcd_data_d = data_q[3:0];
          cnt_d      = S_LOAD;
          state_d    = ST_SETUP;
        end else begin
          cnt_d   = long_q ? XL_LOAD : X_LOAD;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered done lands on the last execution-wait cycle.
    done_d = (state_d == ST_EXEC) && (cnt_d == '0);
  end

  assign up.in_ready = (state_q == ST_IDLE) && !rst;
  assign up.done     = done_q;
  assign lcd_data    = lcd_data_q;
  assign lcd_e       = lcd_e_q;
  assign lcd_rs      = lcd_rs_q;
  assign lcd_rw      = 1'b0;

endmodule
